// File: rtl/lu_sweep_sequencer.sv
// lu_sweep_sequencer: drives every {a,b,select} combo into a logic unit and captures its result.
// Define LU_SWEEP_CHECK_EN to add a golden-model compare with mismatch/err_count.
module lu_sweep_sequencer #(
  parameter int SETTLE = 1,
  parameter int OPS = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        result,
  output logic        a,
  output logic        b,
  output logic [2:0]  select,
  output logic        busy,
  output logic        done,
  output logic [31:0] results,
  output logic [4:0]  count,
  output logic        mismatch,
  output logic [4:0]  err_count
);
  typedef enum logic [1:0] {IDLE, WAIT, CAP, DONE} state_t;
  localparam logic [2:0] LAST = 3'(OPS - 1);
  localparam logic [3:0] SET = 4'(SETTLE);
  localparam state_t HOLD = (SETTLE == 0) ? CAP : WAIT;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] select_n;
  logic a_n, b_n, wrap, cap, go;
  assign wrap = select == LAST;
  assign cap = state == CAP && !abort;
  assign go = state == IDLE && state_n != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    a_n = a;
    b_n = b;
    select_n = select;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = HOLD;
        cnt_n = SET;
      end
      WAIT: if (cnt <= 4'd1) state_n = CAP; else cnt_n = cnt - 4'd1;
      CAP: begin
        state_n = (a && b && wrap) ? DONE : HOLD;
        cnt_n = SET;
        select_n = wrap ? 3'd0 : select + 3'd1;
        b_n = b ^ wrap;
        a_n = a ^ (wrap && b);
      end
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
    if (state_n == IDLE || state_n == DONE) {a_n, b_n, select_n} = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a <= 1'b0;
      b <= 1'b0;
      select <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      results <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      a <= a_n;
      b <= b_n;
      select <= select_n;
      busy <= state_n == WAIT || state_n == CAP;
      done <= state_n == DONE;
      if (go) begin
        results <= '0;
        count <= '0;
      end
      if (cap) begin
        results[{a, b, select}] <= result;
        count <= count + 5'(count != 5'd31);
      end
    end
  end
`ifdef LU_SWEEP_CHECK_EN
  logic [7:0] table_v;
  logic expected, miss;
  always_comb begin
    table_v = {1'b0, ~(a ^ ~b), a ^ ~b, ~(a | ~b), a | ~b, ~(a & ~b), a & ~b, ~a};
    expected = table_v[select];
  end
  assign miss = cap && result != expected;
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch <= 1'b0;
      err_count <= '0;
    end else begin
      mismatch <= miss;
      err_count <= go ? 5'd0 : err_count + 5'(miss && err_count != 5'd31);
    end
  end
`else
  assign mismatch = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_lu_sweep_sequencer.sv
// tb_lu_sweep_sequencer: scoreboard bench for lu_sweep_sequencer (OPS=7/SETTLE=1 and OPS=8/SETTLE=0 instances)
module tb_lu_sweep_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
`ifdef LU_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic st[2], ab[2], fz[2], r[2];
  logic a[2], b[2], busy[2], done[2], mis[2];
  logic [2:0] sel[2];
  logic [31:0] res[2];
  logic [4:0] cnt[2], err[2];
  int errs = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic lu(input logic x, input logic y, input logic [2:0] s);
    logic yi;
    yi = ~y;
    case (s)
      3'd0: return ~x;
      3'd1: return x & yi;
      3'd2: return ~(x & yi);
      3'd3: return x | yi;
      3'd4: return ~(x | yi);
      3'd5: return x ^ yi;
      3'd6: return ~(x ^ yi);
      default: return 1'b0;
    endcase
  endfunction
  assign r[0] = fz[0] ? 1'b0 : lu(a[0], b[0], sel[0]);
  assign r[1] = fz[1] ? 1'b0 : lu(a[1], b[1], sel[1]);
  lu_sweep_sequencer #(.SETTLE(1), .OPS(7)) u0 (
    .clk(clk), .reset(rst), .start(st[0]), .abort(ab[0]), .result(r[0]),
    .a(a[0]), .b(b[0]), .select(sel[0]), .busy(busy[0]), .done(done[0]),
    .results(res[0]), .count(cnt[0]), .mismatch(mis[0]), .err_count(err[0]));
  lu_sweep_sequencer #(.SETTLE(0), .OPS(8)) u1 (
    .clk(clk), .reset(rst), .start(st[1]), .abort(ab[1]), .result(r[1]),
    .a(a[1]), .b(b[1]), .select(sel[1]), .busy(busy[1]), .done(done[1]),
    .results(res[1]), .count(cnt[1]), .mismatch(mis[1]), .err_count(err[1]));
  typedef struct {
    logic [31:0] res;
    logic [4:0] cnt, err;
    int k, done_at, busy_n, mis_n;
  } exp_t;
  exp_t q[$];
  function automatic logic [31:0] golden_vec(input int ops);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] j;
      j = 5'(i);
      if (int'(j[2:0]) < ops) v[i] = lu(j[4], j[3], j[2:0]);
    end
    return v;
  endfunction
  task automatic push(input int dut, input int k, input logic force0);
    exp_t e;
    int n, s1;
    logic [31:0] g;
    n = dut ? 32 : 28;
    s1 = dut ? 1 : 2;
    g = golden_vec(dut ? 8 : 7);
    e.res = force0 ? 32'd0 : g;
    e.cnt = n > 31 ? 5'd31 : 5'(n);
    e.err = (CHK && force0) ? 5'($countones(g)) : 5'd0;
    e.k = k;
    e.done_at = k + n * s1;
    e.busy_n = n * s1;
    e.mis_n = int'(e.err);
    q.push_back(e);
  endtask
  task automatic wait_sweep(input int dut, input bit keep);
    exp_t e;
    int n = 0, bn = 0, mn = 0, first = -1;
    logic seen = 1'b0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      n++;
      if (!keep) st[dut] = 1'b0;
      if (busy[dut]) begin
        bn++;
        if (first < 0) first = cyc;
      end
      if (mis[dut]) mn++;
      seen = done[dut];
    end
    e = q.pop_front();
    checks++;
    if (!seen) begin
      errs++;
      $display("FAIL sweep_timeout dut%0d: no done after %0d cycles", dut, n);
      return;
    end
    checks++;
    if (cyc !== e.done_at) begin errs++; $display("FAIL done_cycle dut%0d: got %0d want %0d", dut, cyc, e.done_at); end
    checks++;
    if (first !== e.k) begin errs++; $display("FAIL busy_start dut%0d: got %0d want %0d", dut, first, e.k); end
    checks++;
    if (bn !== e.busy_n) begin errs++; $display("FAIL busy_cycles dut%0d: got %0d want %0d", dut, bn, e.busy_n); end
    checks++;
    if (mn !== e.mis_n) begin errs++; $display("FAIL mismatch_pulses dut%0d: got %0d want %0d", dut, mn, e.mis_n); end
    checks++;
    if (res[dut] !== e.res) begin errs++; $display("FAIL results dut%0d: got %h want %h", dut, res[dut], e.res); end
    checks++;
    if (cnt[dut] !== e.cnt) begin errs++; $display("FAIL count dut%0d: got %0d want %0d", dut, cnt[dut], e.cnt); end
    checks++;
    if (err[dut] !== e.err) begin errs++; $display("FAIL err_count dut%0d: got %0d want %0d", dut, err[dut], e.err); end
    checks++;
    if ({busy[dut], a[dut], b[dut], sel[dut]} !== 6'd0) begin
      errs++;
      $display("FAIL done_outputs dut%0d: got busy/a/b/select %b want 000000", dut, {busy[dut], a[dut], b[dut], sel[dut]});
    end
  endtask
  task automatic begin_sweep(input int dut, output int k);
    @(negedge clk);
    st[dut] = 1'b1;
    k = cyc + 1;
  endtask
  task automatic test_reset;
    int k;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({a[d], b[d], sel[d], busy[d], done[d], res[d], cnt[d], mis[d], err[d]} !== 50'd0) begin
        errs++;
        $display("FAIL reset_init dut%0d: got %h want 0", d, {a[d], b[d], sel[d], busy[d], done[d], res[d], cnt[d], mis[d], err[d]});
      end
    end
    fz[0] = 1'b1;
    begin_sweep(0, k);
    st[1] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    st[1] = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({a[d], b[d], sel[d], busy[d], done[d], res[d], cnt[d], mis[d], err[d]} !== 50'd0) begin
        errs++;
        $display("FAIL reset_mid dut%0d: got %h want 0", d, {a[d], b[d], sel[d], busy[d], done[d], res[d], cnt[d], mis[d], err[d]});
      end
    end
    rst = 1'b0;
    fz[0] = 1'b0;
    k = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy[0] || busy[1]) k++;
    end
    checks++;
    if (k !== 0) begin errs++; $display("FAIL reset_idle: busy seen %0d cycles want 0", k); end
  endtask
  task automatic test_sweep;
    int k;
    begin_sweep(0, k);
    push(0, k, 1'b0);
    wait_sweep(0, 1'b0);
    checks++;
    if (res[0] !== 32'h2C4A552D) begin errs++; $display("FAIL results_const: got %h want 2c4a552d", res[0]); end
  endtask
  task automatic test_force_zero;
    int k;
    fz[0] = 1'b1;
    begin_sweep(0, k);
    push(0, k, 1'b1);
    wait_sweep(0, 1'b0);
    fz[0] = 1'b0;
  endtask
  task automatic test_abort;
    int k, n = 0, dn = 0;
    begin_sweep(0, k);
    @(negedge clk);
    st[0] = 1'b0;
    while (cyc < k + 10 && n < 100) begin
      @(negedge clk);
      n++;
      if (done[0]) dn++;
    end
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    checks++;
    if ({busy[0], a[0], b[0], sel[0]} !== 6'd0) begin errs++; $display("FAIL abort_idle: got busy/a/b/select %b want 000000", {busy[0], a[0], b[0], sel[0]}); end
    checks++;
    if (cnt[0] !== 5'd5) begin errs++; $display("FAIL abort_count: got %0d want 5", cnt[0]); end
    checks++;
    if (res[0] !== 32'h0000000D) begin errs++; $display("FAIL abort_results: got %h want 0000000d", res[0]); end
    repeat (20) begin
      @(negedge clk);
      if (done[0] || busy[0]) dn++;
    end
    checks++;
    if (dn !== 0) begin errs++; $display("FAIL abort_no_done: got %0d done/busy cycles want 0", dn); end
  endtask
  task automatic test_back_to_back;
    int k;
    begin_sweep(0, k);
    push(0, k, 1'b0);
    wait_sweep(0, 1'b1);
    push(0, k + 58, 1'b0);
    wait_sweep(0, 1'b1);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_ops8;
    int k;
    begin_sweep(1, k);
    push(1, k, 1'b0);
    wait_sweep(1, 1'b0);
    checks++;
    if ((res[1] & 32'h80808080) !== 32'd0) begin errs++; $display("FAIL ops8_bit7: got %h want bit7 of each byte 0", res[1]); end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0;
      ab[d] = 1'b0;
      fz[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_sweep;
    test_force_zero;
    test_abort;
    test_back_to_back;
    test_ops8;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
